// File: rtl/zstr_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : zstr_pkg
// Contents : Shared definitions for the zstr round-robin arbiter:
//            state encoding and a clog2 helper for the grant index width.
// Revision : 1.0  initial release
// ---------------------------------------------------------------------------
package zstr_pkg;

  // Arbiter state encoding
  localparam logic ZSTR_ARB_IDLE = 1'b0;
  localparam logic ZSTR_ARB_BUSY = 1'b1;

  typedef enum logic {
    ST_IDLE = ZSTR_ARB_IDLE,
    ST_BUSY = ZSTR_ARB_BUSY
  } zstr_arb_st_e;

  // Index width for 'value' entries; never below 1 so N=2 still gets a bit.
  function automatic int zstr_clog2(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/zstr_rr_pick.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : zstr_rr_pick
// Contents : Combinational rotate-priority encoder. Returns the first
//            unmasked requester at or after i_ptr, wrapping at N-1 -> 0.
// Revision : 1.0  initial release
// ---------------------------------------------------------------------------
module zstr_rr_pick
  import zstr_pkg::*;
#(
  parameter int N  = 4,
  parameter int GW = zstr_clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [GW-1:0] i_ptr,
  input  logic [N-1:0]  i_mask,
  output logic [GW-1:0] o_idx,
  output logic          o_any
);

  logic [N-1:0] w_req;

  assign w_req = i_req & ~i_mask;

  // Walk ptr, ptr+1, ... (mod N) and latch the first eligible requester.
  always_comb begin
    int w_pos;
    o_idx = '0;
    o_any = 1'b0;
    w_pos = 0;
    for (int k = 0; k < N; k++) begin
      w_pos = int'(i_ptr) + k;
      if (w_pos >= N) begin
        w_pos = w_pos - N;
      end
      if (!o_any && w_req[w_pos]) begin
        o_any = 1'b1;
        o_idx = GW'(w_pos);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/zstr_rr_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : zstr_rr_arbiter
// Contents : N-to-1 round-robin arbiter for zstr valid/ack streams. The
//            winner is latched; its vld/bus go to the master port and m_ack
//            is routed back combinationally to the granted source only.
//            Optional macro ZSTR_ARB_PKT_EN: bus bit BW-1 marks the last beat
//            of a packet and the grant is held until that beat transfers.
// Revision : 1.0  initial release
// ---------------------------------------------------------------------------
module zstr_rr_arbiter
  import zstr_pkg::*;
#(
  parameter int N  = 4,
  parameter int BW = 8,
  parameter int GW = zstr_clog2(N)
) (
  input  logic            z_clk,
  input  logic            z_rst,
  input  logic [N-1:0]    s_vld,
  input  logic [N*BW-1:0] s_bus,
  output logic [N-1:0]    s_ack,
  output logic            m_vld,
  output logic [BW-1:0]   m_bus,
  input  logic            m_ack,
  output logic [GW-1:0]   m_gnt,
  output logic            m_own
);

  zstr_arb_st_e  r_st;
  zstr_arb_st_e  w_st_nxt;
  logic [GW-1:0] r_gnt;
  logic [GW-1:0] w_gnt_nxt;
  logic [GW-1:0] r_ptr;
  logic [GW-1:0] w_ptr_nxt;

  logic          w_busy;
  logic [N-1:0]  w_gnt_oh;
  logic [BW-1:0] w_sel_bus;
  logic          w_sel_vld;
  logic          w_xfer;
  logic          w_rel;
  logic [GW-1:0] w_ptr_inc;
  logic [GW-1:0] w_pick_ptr;
  logic [N-1:0]  w_pick_mask;
  logic [GW-1:0] w_pick_idx;
  logic          w_pick_any;

  assign w_busy = (r_st == ST_BUSY);

  // Decode the granted source: one-hot select plus its bus slice.
  always_comb begin
    w_gnt_oh  = '0;
    w_sel_bus = '0;
    for (int i = 0; i < N; i++) begin
      if (r_gnt == GW'(i)) begin
        w_gnt_oh[i] = 1'b1;
        w_sel_bus   = s_bus[i*BW +: BW];
      end
    end
  end

  assign w_sel_vld = |(s_vld & w_gnt_oh);

  // Master/slave port outputs; everything is quiet outside BUSY.
  always_comb begin
    m_own = w_busy;
    m_gnt = r_gnt;
    m_vld = w_busy & w_sel_vld;
    m_bus = w_busy ? w_sel_bus : '0;
    s_ack = (w_busy && m_ack) ? w_gnt_oh : '0;
  end

  assign w_xfer = m_vld & m_ack;

`ifdef ZSTR_ARB_PKT_EN
  // Only the beat carrying the last flag gives up the grant.
  assign w_rel = w_xfer & m_bus[BW-1];
`else
  assign w_rel = w_xfer;
`endif

  // Next priority pointer: one past the releasing source, wrapping at N-1.
  assign w_ptr_inc = (r_gnt == GW'(N-1)) ? '0 : r_gnt + GW'(1);

  // On a release the pick already sees the advanced pointer and skips the
  // releasing source, so a competing requester is granted with no bubble.
  assign w_pick_ptr  = w_rel ? w_ptr_inc : r_ptr;
  assign w_pick_mask = w_rel ? w_gnt_oh : '0;

  zstr_rr_pick #(
    .N  (N),
    .GW (GW)
  ) u_pick (
    .i_req  (s_vld),
    .i_ptr  (w_pick_ptr),
    .i_mask (w_pick_mask),
    .o_idx  (w_pick_idx),
    .o_any  (w_pick_any)
  );

  // Next-state: grant from IDLE, hand over or drop back to IDLE on release.
  always_comb begin
    w_st_nxt  = r_st;
    w_gnt_nxt = r_gnt;
    w_ptr_nxt = r_ptr;
    case (r_st)
      ST_IDLE: begin
        if (w_pick_any) begin
          w_gnt_nxt = w_pick_idx;
          w_st_nxt  = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (w_rel) begin
          w_ptr_nxt = w_ptr_inc;
          if (w_pick_any) begin
            w_gnt_nxt = w_pick_idx;
          end else begin
            w_st_nxt = ST_IDLE;
          end
        end
      end
      default: begin
        w_st_nxt = ST_IDLE;
      end
    endcase
  end

  // State, grant and pointer registers with asynchronous clear.
  always_ff @(posedge z_clk or posedge z_rst) begin
    if (z_rst) begin
      r_st  <= ST_IDLE;
      r_gnt <= '0;
      r_ptr <= '0;
    end else begin
      r_st  <= w_st_nxt;
      r_gnt <= w_gnt_nxt;
      r_ptr <= w_ptr_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_zstr_rr_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : tb_zstr_rr_arbiter
// Contents : Self-checking bench for zstr_rr_arbiter (N=4 and N=3 copies).
//            Source models hold a beat queue per source; every transfer seen
//            on the master port is compared against an expected queue.
// Revision : 1.0  initial release
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_zstr_rr_arbiter;

  logic z_clk = 1'b0;
  logic z_rst = 1'b0;
  always #5 z_clk = ~z_clk;

  logic [3:0]  s_vld4 = '0;
  logic [31:0] s_bus4 = '0;
  logic [3:0]  s_ack4;
  logic        m_vld4;
  logic [7:0]  m_bus4;
  logic        m_ack4 = 1'b0;
  logic [1:0]  m_gnt4;
  logic        m_own4;

  logic [2:0]  s_vld3 = '0;
  logic [23:0] s_bus3 = '0;
  logic [2:0]  s_ack3;
  logic        m_vld3;
  logic [7:0]  m_bus3;
  logic        m_ack3 = 1'b0;
  logic [1:0]  m_gnt3;
  logic        m_own3;

  zstr_rr_arbiter #(.N(4), .BW(8)) dut4 (
    .z_clk(z_clk), .z_rst(z_rst), .s_vld(s_vld4), .s_bus(s_bus4), .s_ack(s_ack4),
    .m_vld(m_vld4), .m_bus(m_bus4), .m_ack(m_ack4), .m_gnt(m_gnt4), .m_own(m_own4)
  );

  zstr_rr_arbiter #(.N(3), .BW(8)) dut3 (
    .z_clk(z_clk), .z_rst(z_rst), .s_vld(s_vld3), .s_bus(s_bus3), .s_ack(s_ack3),
    .m_vld(m_vld3), .m_bus(m_bus3), .m_ack(m_ack3), .m_gnt(m_gnt3), .m_own(m_own3)
  );

  typedef struct {
    int         dut;
    int         gnt;
    logic [7:0] bus;
    logic [3:0] ack;
    int         cyc;
  } xfer_t;

  xfer_t      obs_q[$];
  xfer_t      exp_q[$];
  logic [7:0] q4[4][$];
  logic [7:0] q3[3][$];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic       snap_vld4, snap_own4;
  logic [1:0] snap_gnt4;
  logic [7:0] snap_bus4;
  logic [3:0] snap_ack4;

  // Present the head of each source queue on the DUT inputs.
  task automatic refresh();
    for (int i = 0; i < 4; i++) begin
      s_vld4[i]         = (q4[i].size() != 0);
      s_bus4[i*8 +: 8]  = (q4[i].size() != 0) ? q4[i][0] : 8'h00;
    end
    for (int i = 0; i < 3; i++) begin
      s_vld3[i]         = (q3[i].size() != 0);
      s_bus3[i*8 +: 8]  = (q3[i].size() != 0) ? q3[i][0] : 8'h00;
    end
  endtask

  // One clock: sample at negedge, record transfers, then advance sources.
  task automatic step();
    logic [3:0] acked4;
    logic [2:0] acked3;
    @(negedge z_clk);
    snap_vld4 = m_vld4; snap_own4 = m_own4; snap_gnt4 = m_gnt4;
    snap_bus4 = m_bus4; snap_ack4 = s_ack4;
    if (m_vld4 && m_ack4)
      obs_q.push_back('{dut: 4, gnt: int'(m_gnt4), bus: m_bus4, ack: s_ack4, cyc: cyc});
    if (m_vld3 && m_ack3)
      obs_q.push_back('{dut: 3, gnt: int'(m_gnt3), bus: m_bus3, ack: {1'b0, s_ack3}, cyc: cyc});
    acked4 = s_vld4 & s_ack4;
    acked3 = s_vld3 & s_ack3;
    @(posedge z_clk);
    cyc = cyc + 1;
    #1;
    for (int i = 0; i < 4; i++) if (acked4[i] && q4[i].size() != 0) void'(q4[i].pop_front());
    for (int i = 0; i < 3; i++) if (acked3[i] && q3[i].size() != 0) void'(q3[i].pop_front());
    refresh();
  endtask

  task automatic expect_x(input int dut, input int gnt, input logic [7:0] bus, input int c);
    exp_q.push_back('{dut: dut, gnt: gnt, bus: bus, ack: 4'(1 << gnt), cyc: c});
  endtask

  task automatic do_reset();
    for (int i = 0; i < 4; i++) q4[i].delete();
    for (int i = 0; i < 3; i++) q3[i].delete();
    m_ack4 = 1'b0;
    m_ack3 = 1'b0;
    refresh();
    z_rst = 1'b1;
    @(posedge z_clk);
    #1;
    z_rst = 1'b0;
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 4; i++) for (int b = 0; b < 6; b++) q4[i].push_back(8'(i * 16 + b));
    for (int i = 0; i < 3; i++) for (int b = 0; b < 6; b++) q3[i].push_back(8'(i * 16 + b));
    m_ack4 = 1'b1;
    m_ack3 = 1'b1;
    refresh();
    step(); step(); step();
    checks++;
    if (m_own4 !== 1'b1 || m_gnt4 !== 2'd2) begin
      errors++;
      $display("FAIL reset_pre: own=%b gnt=%0d, want own=1 gnt=2", m_own4, m_gnt4);
    end
    #2;
    z_rst = 1'b1;
    #1;
    checks++;
    if (m_vld4 !== 1'b0) begin errors++; $display("FAIL reset_async_vld: got %b want 0", m_vld4); end
    checks++;
    if (s_ack4 !== 4'b0) begin errors++; $display("FAIL reset_async_ack: got %b want 0000", s_ack4); end
    checks++;
    if (m_gnt4 !== 2'd0) begin errors++; $display("FAIL reset_async_gnt: got %0d want 0", m_gnt4); end
    checks++;
    if (m_own4 !== 1'b0) begin errors++; $display("FAIL reset_async_own: got %b want 0", m_own4); end
    checks++;
    if (m_bus4 !== 8'h00) begin errors++; $display("FAIL reset_async_bus: got %h want 00", m_bus4); end
    checks++;
    if ({m_vld3, m_own3, s_ack3, m_gnt3} !== 7'b0) begin
      errors++;
      $display("FAIL reset_async_n3: vld=%b own=%b ack=%b gnt=%0d want all 0", m_vld3, m_own3, s_ack3, m_gnt3);
    end
    @(posedge z_clk); @(posedge z_clk); #1;
    checks++;
    if ({m_vld4, m_own4, s_ack4} !== 6'b0) begin
      errors++;
      $display("FAIL reset_held: vld=%b own=%b ack=%b want all 0", m_vld4, m_own4, s_ack4);
    end
    do_reset();
  endtask

  task automatic test_single_source();
    int c0;
    xfer_t o, e;
    do_reset();
    m_ack4 = 1'b1;
    q4[2].push_back(8'hA5);
    refresh();
    c0 = cyc;
    expect_x(4, 2, 8'hA5, c0 + 1);
    step();
    checks++;
    if (snap_own4 !== 1'b0 || snap_vld4 !== 1'b0) begin
      errors++;
      $display("FAIL single_latency: own=%b vld=%b in arbitration cycle, want 0 0", snap_own4, snap_vld4);
    end
    step(); step();
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL single: no transfer, want src%0d bus %h", e.gnt, e.bus); end
      else begin
        o = obs_q.pop_front();
        if (o.dut !== e.dut || o.gnt !== e.gnt || o.bus !== e.bus || o.ack !== e.ack || o.cyc !== e.cyc) begin
          errors++;
          $display("FAIL single: got src%0d bus %h ack %b cyc %0d, want src%0d bus %h ack %b cyc %0d",
                   o.gnt, o.bus, o.ack, o.cyc, e.gnt, e.bus, e.ack, e.cyc);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin errors++; $display("FAIL single_extra: %0d extra transfers, want 0", obs_q.size()); end
  endtask

  task automatic test_fairness();
    int c0;
    xfer_t o, e;
    do_reset();
    m_ack4 = 1'b1;
    for (int i = 0; i < 4; i++) for (int b = 0; b < 2; b++) q4[i].push_back(8'(i * 16 + b));
    refresh();
    c0 = cyc;
    for (int k = 0; k < 8; k++) expect_x(4, k % 4, 8'((k % 4) * 16 + k / 4), c0 + 1 + k);
    for (int k = 0; k < 10; k++) step();
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL fairness: no transfer, want src%0d bus %h", e.gnt, e.bus); end
      else begin
        o = obs_q.pop_front();
        if (o.dut !== e.dut || o.gnt !== e.gnt || o.bus !== e.bus || o.ack !== e.ack || o.cyc !== e.cyc) begin
          errors++;
          $display("FAIL fairness: got src%0d bus %h ack %b cyc %0d, want src%0d bus %h ack %b cyc %0d",
                   o.gnt, o.bus, o.ack, o.cyc, e.gnt, e.bus, e.ack, e.cyc);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0 || snap_own4 !== 1'b0) begin
      errors++;
      $display("FAIL fairness_end: extra=%0d own=%b, want 0 0", obs_q.size(), snap_own4);
    end
  endtask

  task automatic test_backpressure();
    int c0;
    xfer_t o, e;
    do_reset();
    q4[1].push_back(8'h11);
    q4[3].push_back(8'h33);
    refresh();
    c0 = cyc;
    step();
    q4[0].push_back(8'h00);
    refresh();
    for (int k = 0; k < 5; k++) begin
      step();
      checks++;
      if (snap_gnt4 !== 2'd1 || snap_bus4 !== 8'h11 || snap_ack4 !== 4'b0 || snap_own4 !== 1'b1) begin
        errors++;
        $display("FAIL backpressure_hold: gnt=%0d bus=%h ack=%b own=%b, want 1 11 0000 1",
                 snap_gnt4, snap_bus4, snap_ack4, snap_own4);
      end
    end
    m_ack4 = 1'b1;
    expect_x(4, 1, 8'h11, c0 + 6);
    expect_x(4, 3, 8'h33, c0 + 7);
    expect_x(4, 0, 8'h00, c0 + 8);
    for (int k = 0; k < 4; k++) step();
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL backpressure: no transfer, want src%0d bus %h", e.gnt, e.bus); end
      else begin
        o = obs_q.pop_front();
        if (o.dut !== e.dut || o.gnt !== e.gnt || o.bus !== e.bus || o.ack !== e.ack || o.cyc !== e.cyc) begin
          errors++;
          $display("FAIL backpressure: got src%0d bus %h ack %b cyc %0d, want src%0d bus %h ack %b cyc %0d",
                   o.gnt, o.bus, o.ack, o.cyc, e.gnt, e.bus, e.ack, e.cyc);
        end
      end
    end
  endtask

  task automatic test_vld_drop();
    int c1;
    xfer_t o, e;
    do_reset();
    q4[1].push_back(8'h44);
    refresh();
    step();
    q4[1].delete();
    q4[2].push_back(8'h55);
    refresh();
    for (int k = 0; k < 2; k++) begin
      step();
      checks++;
      if (snap_own4 !== 1'b1 || snap_vld4 !== 1'b0 || snap_gnt4 !== 2'd1 || snap_ack4 !== 4'b0) begin
        errors++;
        $display("FAIL vld_drop_hold: own=%b vld=%b gnt=%0d ack=%b, want 1 0 1 0000",
                 snap_own4, snap_vld4, snap_gnt4, snap_ack4);
      end
    end
    m_ack4 = 1'b1;
    q4[1].push_back(8'h46);
    refresh();
    c1 = cyc;
    expect_x(4, 1, 8'h46, c1);
    expect_x(4, 2, 8'h55, c1 + 1);
    for (int k = 0; k < 3; k++) step();
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL vld_drop: no transfer, want src%0d bus %h", e.gnt, e.bus); end
      else begin
        o = obs_q.pop_front();
        if (o.dut !== e.dut || o.gnt !== e.gnt || o.bus !== e.bus || o.ack !== e.ack || o.cyc !== e.cyc) begin
          errors++;
          $display("FAIL vld_drop: got src%0d bus %h ack %b cyc %0d, want src%0d bus %h ack %b cyc %0d",
                   o.gnt, o.bus, o.ack, o.cyc, e.gnt, e.bus, e.ack, e.cyc);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int c0;
    xfer_t o, e;
    do_reset();
    m_ack4 = 1'b1;
    q4[2].push_back(8'hA1);
    q4[2].push_back(8'hA2);
    refresh();
    c0 = cyc;
    expect_x(4, 2, 8'hA1, c0 + 1);
    expect_x(4, 2, 8'hA2, c0 + 3);
    step(); step(); step();
    checks++;
    if (snap_own4 !== 1'b0) begin
      errors++;
      $display("FAIL b2b_sole_idle: own=%b after sole-source release, want 0", snap_own4);
    end
    step();
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL b2b: no transfer, want src%0d bus %h", e.gnt, e.bus); end
      else begin
        o = obs_q.pop_front();
        if (o.dut !== e.dut || o.gnt !== e.gnt || o.bus !== e.bus || o.ack !== e.ack || o.cyc !== e.cyc) begin
          errors++;
          $display("FAIL b2b: got src%0d bus %h ack %b cyc %0d, want src%0d bus %h ack %b cyc %0d",
                   o.gnt, o.bus, o.ack, o.cyc, e.gnt, e.bus, e.ack, e.cyc);
        end
      end
    end
  endtask

  task automatic test_wrap_n3();
    int c;
    xfer_t o, e;
    do_reset();
    m_ack3 = 1'b1;
    q3[1].push_back(8'h10);
    refresh();
    c = cyc;
    expect_x(3, 1, 8'h10, c + 1);
    for (int k = 0; k < 3; k++) step();
    q3[2].push_back(8'h20);
    q3[0].push_back(8'h00);
    refresh();
    c = cyc;
    expect_x(3, 2, 8'h20, c + 1);
    expect_x(3, 0, 8'h00, c + 2);
    for (int k = 0; k < 4; k++) step();
    q3[0].push_back(8'h01);
    q3[1].push_back(8'h11);
    q3[2].push_back(8'h21);
    refresh();
    c = cyc;
    expect_x(3, 1, 8'h11, c + 1);
    expect_x(3, 2, 8'h21, c + 2);
    expect_x(3, 0, 8'h01, c + 3);
    for (int k = 0; k < 5; k++) step();
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL wrap_n3: no transfer, want src%0d bus %h", e.gnt, e.bus); end
      else begin
        o = obs_q.pop_front();
        if (o.dut !== e.dut || o.gnt !== e.gnt || o.bus !== e.bus || o.ack !== e.ack || o.cyc !== e.cyc) begin
          errors++;
          $display("FAIL wrap_n3: got src%0d bus %h ack %b cyc %0d, want src%0d bus %h ack %b cyc %0d",
                   o.gnt, o.bus, o.ack, o.cyc, e.gnt, e.bus, e.ack, e.cyc);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin errors++; $display("FAIL wrap_n3_extra: %0d extra transfers, want 0", obs_q.size()); end
  endtask

  task automatic test_packet();
    int c0;
    xfer_t o, e;
    do_reset();
    m_ack4 = 1'b1;
    q4[1].push_back(8'h01);
    q4[1].push_back(8'h02);
    q4[1].push_back(8'h83);
    refresh();
    c0 = cyc;
    step();
    q4[0].push_back(8'h85);
    refresh();
`ifdef ZSTR_ARB_PKT_EN
    expect_x(4, 1, 8'h01, c0 + 1);
    expect_x(4, 1, 8'h02, c0 + 2);
    expect_x(4, 1, 8'h83, c0 + 3);
    expect_x(4, 0, 8'h85, c0 + 4);
`else
    expect_x(4, 1, 8'h01, c0 + 1);
    expect_x(4, 0, 8'h85, c0 + 2);
    expect_x(4, 1, 8'h02, c0 + 3);
    expect_x(4, 1, 8'h83, c0 + 5);
`endif
    for (int k = 0; k < 6; k++) step();
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL packet: no transfer, want src%0d bus %h", e.gnt, e.bus); end
      else begin
        o = obs_q.pop_front();
        if (o.dut !== e.dut || o.gnt !== e.gnt || o.bus !== e.bus || o.ack !== e.ack || o.cyc !== e.cyc) begin
          errors++;
          $display("FAIL packet: got src%0d bus %h ack %b cyc %0d, want src%0d bus %h ack %b cyc %0d",
                   o.gnt, o.bus, o.ack, o.cyc, e.gnt, e.bus, e.ack, e.cyc);
        end
      end
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_single_source();
    test_fairness();
    test_backpressure();
    test_vld_drop();
    test_back_to_back();
    test_wrap_n3();
    test_packet();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
